bus_sram_responder: RTL and testbench

- Bus slave (responder) for the shared burst bus: accepts single and burst writes into an on-chip word SRAM and returns single and burst reads.
- Serves as the frame-buffer target for bus masters such as the camera grabber, and as the read source for display or processing masters.
- Decodes one address window; beats outside the window are ignored so other slaves can respond on the same wired-OR bus.

---
 rtl/bus_sram_pkg.sv | 17 +
 rtl/sram_word_be.sv | 34 +++
 rtl/bus_sram_responder.sv | 183 ++++++++++++++++++
 tb/tb_bus_sram_responder.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sram_pkg.sv
// Shared types and widths for the bus SRAM responder.
package bus_sram_pkg;

    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int BURST_W = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE      = 3'd1,
        READ_ADDR  = 3'd2,
        READ_BURST = 3'd3,
        END_READ   = 3'd4,
        ERROR      = 3'd5
    } state_t;

endpackage

// File: rtl/sram_word_be.sv
// Single-port word SRAM, one byte-wide array per lane so each lane maps to its own block RAM.
module sram_word_be
    import bus_sram_pkg::*;
#(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              en,
    input  logic [BE_W-1:0]   we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q_reg;

            always_ff @(posedge clk) begin
                if (en && we[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
                if (en) begin
                    lane_q_reg <= lane_mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = lane_q_reg;
        end
    endgenerate

endmodule

// File: rtl/bus_sram_responder.sv
// Burst-bus slave backed by a word SRAM; single and burst reads/writes inside one address window.
// Optional BUS_SRAM_OVERRUN_ERROR_EN turns count overruns and window-top crossings into bus errors.
module bus_sram_responder
    import bus_sram_pkg::*;
#(
    parameter logic [31:0] baseAddress = 32'h40000000,
    parameter int          sizeInWords = 2048
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               beginTransactionIn,
    input  logic [DATA_W-1:0]  addressDataIn,
    input  logic               readNotWriteIn,
    input  logic [BE_W-1:0]    byteEnablesIn,
    input  logic [BURST_W-1:0] burstSizeIn,
    input  logic               dataValidIn,
    input  logic               endTransactionIn,
    output logic [DATA_W-1:0]  addressDataOut,
    output logic               dataValidOut,
    output logic               endTransactionOut,
    output logic               busyOut,
    output logic               busErrorOut
);

    localparam int AW = $clog2(sizeInWords) - 1;

    state_t              state_reg, state_next;
    logic [AW:0]         word_addr_reg, word_addr_next;
    logic [BURST_W:0]    beats_left_reg, beats_left_next;
    logic [BE_W-1:0]     be_reg, be_next;
    logic                err_pulse_reg, err_pulse_next;

    logic                hit;
    logic                misaligned;
    logic                begin_overrun;
    logic                write_beat;
    logic [AW:0]         begin_word;
    logic                sram_en;
    logic [BE_W-1:0]     sram_we;
    logic [DATA_W-1:0]   sram_rdata;

    assign hit        = beginTransactionIn &&
                        (addressDataIn[31:AW+3] == baseAddress[31:AW+3]);
    assign misaligned = (addressDataIn[1:0] != 2'b00);
    assign begin_word = addressDataIn[AW+2:2];
    // Bit BURST_W of the beat counter going high means the burst count is used up.
    assign write_beat = dataValidIn && !beats_left_reg[BURST_W];

`ifdef BUS_SRAM_OVERRUN_ERROR_EN
    logic [31:0] last_word;
    assign last_word     = 32'(begin_word) + 32'(burstSizeIn);
    assign begin_overrun = (last_word > 32'(sizeInWords - 1));
`else
    assign begin_overrun = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            word_addr_reg  <= '0;
            beats_left_reg <= '0;
            be_reg         <= '0;
            err_pulse_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            word_addr_reg  <= word_addr_next;
            beats_left_reg <= beats_left_next;
            be_reg         <= be_next;
            err_pulse_reg  <= err_pulse_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        word_addr_next  = word_addr_reg;
        beats_left_next = beats_left_reg;
        be_next         = be_reg;
        err_pulse_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (hit) begin
                    word_addr_next  = begin_word;
                    beats_left_next = {1'b0, burstSizeIn};
                    be_next         = byteEnablesIn;
                    if (misaligned || begin_overrun) begin
                        state_next     = ERROR;
                        err_pulse_next = 1'b1;
                    end else if (readNotWriteIn) begin
                        state_next = READ_ADDR;
                    end else begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                if (write_beat) begin
                    word_addr_next  = word_addr_reg + 1'b1;
                    beats_left_next = beats_left_reg - 1'b1;
                end
`ifdef BUS_SRAM_OVERRUN_ERROR_EN
                if (dataValidIn && beats_left_reg[BURST_W]) begin
                    state_next     = ERROR;
                    err_pulse_next = 1'b1;
                end else if (endTransactionIn) begin
                    state_next = IDLE;
                end
`else
                if (endTransactionIn) begin
                    state_next = IDLE;
                end
`endif
            end
            READ_ADDR: begin
                word_addr_next = word_addr_reg + 1'b1;
                state_next     = endTransactionIn ? IDLE : READ_BURST;
            end
            READ_BURST: begin
                if (endTransactionIn) begin
                    state_next = IDLE;
                end else begin
                    word_addr_next  = word_addr_reg + 1'b1;
                    beats_left_next = beats_left_reg - 1'b1;
                    if (beats_left_reg == '0) begin
                        state_next = END_READ;
                    end
                end
            end
            END_READ: begin
                state_next = IDLE;
            end
            ERROR: begin
                if (endTransactionIn) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        sram_en           = 1'b0;
        sram_we           = '0;
        dataValidOut      = 1'b0;
        addressDataOut    = '0;
        endTransactionOut = 1'b0;
        busyOut           = 1'b0;
        busErrorOut       = err_pulse_reg;
        case (state_reg)
            WRITE: begin
                sram_en = write_beat;
                sram_we = write_beat ? be_reg : '0;
            end
            READ_ADDR: begin
                sram_en = 1'b1;
            end
            READ_BURST: begin
                sram_en        = 1'b1;
                dataValidOut   = 1'b1;
                addressDataOut = sram_rdata;
            end
            END_READ: begin
                endTransactionOut = 1'b1;
            end
            default: begin
            end
        endcase
    end

    sram_word_be #(
        .DEPTH  (sizeInWords),
        .ADDR_W (AW + 1)
    ) u_sram (
        .clk   (clock),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (word_addr_reg),
        .wdata (addressDataIn),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed self-checking bench for bus_sram_responder.
module tb_bus_sram_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic        readNotWriteIn;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busyOut;
    logic        busErrorOut;

    int          pass_count = 0;
    int          check_count = 0;
    logic [31:0] wbuf [16];

    bus_sram_responder dut (
        .clock             (clock),
        .reset             (reset),
        .beginTransactionIn(beginTransactionIn),
        .addressDataIn     (addressDataIn),
        .readNotWriteIn    (readNotWriteIn),
        .byteEnablesIn     (byteEnablesIn),
        .burstSizeIn       (burstSizeIn),
        .dataValidIn       (dataValidIn),
        .endTransactionIn  (endTransactionIn),
        .addressDataOut    (addressDataOut),
        .dataValidOut      (dataValidOut),
        .endTransactionOut (endTransactionOut),
        .busyOut           (busyOut),
        .busErrorOut       (busErrorOut)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] be,
                               input logic [7:0] burst, input int nbeats);
        cyc();
        beginTransactionIn = 1'b1; addressDataIn = addr; readNotWriteIn = 1'b0;
        byteEnablesIn = be; burstSizeIn = burst;
        for (int i = 0; i < nbeats; i++) begin
            cyc();
            beginTransactionIn = 1'b0; dataValidIn = 1'b1; addressDataIn = wbuf[i];
        end
        cyc();
        beginTransactionIn = 1'b0; dataValidIn = 1'b0; addressDataIn = '0; endTransactionIn = 1'b1;
        cyc();
        endTransactionIn = 1'b0;
        $display("write addr=%08h be=%h burst=%0d beats=%0d", addr, be, burst, nbeats);
    endtask

    task automatic read_single(input logic [31:0] addr, output logic [31:0] data, output bit got);
        got = 1'b0; data = '0;
        cyc();
        beginTransactionIn = 1'b1; addressDataIn = addr; readNotWriteIn = 1'b1;
        byteEnablesIn = 4'hF; burstSizeIn = 8'd0;
        cyc();
        beginTransactionIn = 1'b0; addressDataIn = '0;
        for (int i = 0; i < 6 && !got; i++) begin
            if (dataValidOut === 1'b1) begin
                got = 1'b1; data = addressDataOut;
            end else begin
                cyc();
            end
        end
        repeat (2) cyc();
        $display("read addr=%08h data=%08h got=%0b", addr, data, got);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        check_count++;
        if (addressDataOut !== 32'h0) $display("FAIL reset_data: got %08h expected 00000000", addressDataOut); else pass_count++;
        check_count++;
        if (dataValidOut !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", dataValidOut); else pass_count++;
        check_count++;
        if (endTransactionOut !== 1'b0) $display("FAIL reset_end: got %0b expected 0", endTransactionOut); else pass_count++;
        check_count++;
        if (busyOut !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busyOut); else pass_count++;
        check_count++;
        if (busErrorOut !== 1'b0) $display("FAIL reset_err: got %0b expected 0", busErrorOut); else pass_count++;
        reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_write_burst();
        logic [31:0] rd;
        bit          got;
        wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
        wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
        write_burst(32'h40000010, 4'hF, 8'd3, 4);
        cyc();
        beginTransactionIn = 1'b1; addressDataIn = 32'h40000018; readNotWriteIn = 1'b1;
        byteEnablesIn = 4'hF; burstSizeIn = 8'd0;
        cyc();
        beginTransactionIn = 1'b0; addressDataIn = '0;
        check_count++;
        if (dataValidOut !== 1'b0) $display("FAIL rd_lat_c1: got %0b expected 0", dataValidOut); else pass_count++;
        cyc();
        check_count++;
        if (dataValidOut !== 1'b1 || addressDataOut !== 32'h33333333)
            $display("FAIL rd_beat_c2: got v=%0b d=%08h expected v=1 d=33333333", dataValidOut, addressDataOut);
        else pass_count++;
        cyc();
        check_count++;
        if (endTransactionOut !== 1'b1 || dataValidOut !== 1'b0 || addressDataOut !== 32'h0)
            $display("FAIL rd_end_c3: got e=%0b v=%0b d=%08h expected e=1 v=0 d=0", endTransactionOut, dataValidOut, addressDataOut);
        else pass_count++;
        cyc();
        check_count++;
        if (endTransactionOut !== 1'b0) $display("FAIL rd_end_c4: got %0b expected 0", endTransactionOut); else pass_count++;
        $display("single read at 40000018 timed");
        read_single(32'h40000010, rd, got);
        check_count++;
        if (!got || rd !== 32'h11111111) $display("FAIL wr_word4: got %08h (got=%0b) expected 11111111", rd, got); else pass_count++;
        read_single(32'h4000001C, rd, got);
        check_count++;
        if (!got || rd !== 32'h44444444) $display("FAIL wr_word7: got %08h (got=%0b) expected 44444444", rd, got); else pass_count++;
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd;
        bit          got;
        wbuf[0] = 32'h0;
        write_burst(32'h40000000, 4'hF, 8'd0, 1);
        wbuf[0] = 32'hAABBCCDD;
        write_burst(32'h40000000, 4'b0101, 8'd0, 1);
        read_single(32'h40000000, rd, got);
        check_count++;
        if (!got || rd !== 32'h00BB00DD) $display("FAIL byte_en: got %08h (got=%0b) expected 00BB00DD", rd, got); else pass_count++;
    endtask

    task automatic test_miss();
        logic [31:0] rd;
        bit          got;
        cyc();
        beginTransactionIn = 1'b1; addressDataIn = 32'h50000000; readNotWriteIn = 1'b0;
        byteEnablesIn = 4'hF; burstSizeIn = 8'd1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            beginTransactionIn = 1'b0;
            dataValidIn = (i < 2); endTransactionIn = (i == 2);
            addressDataIn = 32'hDEADBEEF;
            check_count++;
            if ({dataValidOut, endTransactionOut, busyOut, busErrorOut} !== 4'b0 || addressDataOut !== 32'h0)
                $display("FAIL miss_quiet_%0d: got v=%0b e=%0b b=%0b err=%0b d=%08h expected all 0",
                         i, dataValidOut, endTransactionOut, busyOut, busErrorOut, addressDataOut);
            else pass_count++;
        end
        dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = '0;
        read_single(32'h40000000, rd, got);
        check_count++;
        if (!got || rd !== 32'h00BB00DD) $display("FAIL miss_unchanged: got %08h (got=%0b) expected 00BB00DD", rd, got); else pass_count++;
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        bit          got;
        cyc();
        beginTransactionIn = 1'b1; addressDataIn = 32'h40000002; readNotWriteIn = 1'b0;
        byteEnablesIn = 4'hF; burstSizeIn = 8'd1;
        check_count++;
        if (busErrorOut !== 1'b0) $display("FAIL misalign_c0: got %0b expected 0", busErrorOut); else pass_count++;
        cyc();
        beginTransactionIn = 1'b0; dataValidIn = 1'b1; addressDataIn = 32'hFFFFFFFF;
        check_count++;
        if (busErrorOut !== 1'b1) $display("FAIL misalign_c1: got %0b expected 1", busErrorOut); else pass_count++;
        cyc();
        check_count++;
        if (busErrorOut !== 1'b0) $display("FAIL misalign_c2: got %0b expected 0", busErrorOut); else pass_count++;
        dataValidIn = 1'b0; addressDataIn = '0; endTransactionIn = 1'b1;
        cyc();
        endTransactionIn = 1'b0;
        check_count++;
        if (busErrorOut !== 1'b0 || dataValidOut !== 1'b0) $display("FAIL misalign_c3: got err=%0b v=%0b expected 0 0", busErrorOut, dataValidOut); else pass_count++;
        read_single(32'h40000000, rd, got);
        check_count++;
        if (!got || rd !== 32'h00BB00DD) $display("FAIL misalign_nowrite: got %08h (got=%0b) expected 00BB00DD", rd, got); else pass_count++;
    endtask

    task automatic test_read_abort();
        logic [31:0] rd;
        bit          got;
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h10000000 + 32'(i) * 32'h0101;
        write_burst(32'h40000000, 4'hF, 8'd15, 16);
        cyc();
        beginTransactionIn = 1'b1; addressDataIn = 32'h40000000; readNotWriteIn = 1'b1;
        byteEnablesIn = 4'hF; burstSizeIn = 8'd15;
        cyc();
        beginTransactionIn = 1'b0; addressDataIn = '0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check_count++;
            if (dataValidOut !== 1'b1 || addressDataOut !== wbuf[k])
                $display("FAIL abort_beat%0d: got v=%0b d=%08h expected v=1 d=%08h", k, dataValidOut, addressDataOut, wbuf[k]);
            else pass_count++;
            if (k == 4) endTransactionIn = 1'b1;
        end
        cyc();
        endTransactionIn = 1'b0;
        check_count++;
        if (dataValidOut !== 1'b0 || endTransactionOut !== 1'b0 || addressDataOut !== 32'h0)
            $display("FAIL abort_after: got v=%0b e=%0b d=%08h expected 0 0 0", dataValidOut, endTransactionOut, addressDataOut);
        else pass_count++;
        cyc();
        check_count++;
        if (endTransactionOut !== 1'b0) $display("FAIL abort_noend: got %0b expected 0", endTransactionOut); else pass_count++;
        read_single(32'h4000000C, rd, got);
        check_count++;
        if (!got || rd !== 32'h10000303) $display("FAIL abort_next: got %08h (got=%0b) expected 10000303", rd, got); else pass_count++;
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        bit          got;
        wbuf[0] = 32'h0BADF00D;
        write_burst(32'h40000000, 4'hF, 8'd0, 1);
        wbuf[0] = 32'h77777777;
        write_burst(32'h40001FFC, 4'hF, 8'd0, 1);
        wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002;
`ifdef BUS_SRAM_OVERRUN_ERROR_EN
        cyc();
        beginTransactionIn = 1'b1; addressDataIn = 32'h40001FFC; readNotWriteIn = 1'b0;
        byteEnablesIn = 4'hF; burstSizeIn = 8'd1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            beginTransactionIn = 1'b0; dataValidIn = 1'b1; addressDataIn = wbuf[i];
            check_count++;
            if (busErrorOut !== (i == 0)) $display("FAIL wrap_err_c%0d: got %0b expected %0b", i + 1, busErrorOut, (i == 0)); else pass_count++;
        end
        cyc();
        dataValidIn = 1'b0; addressDataIn = '0; endTransactionIn = 1'b1;
        cyc();
        endTransactionIn = 1'b0;
        read_single(32'h40001FFC, rd, got);
        check_count++;
        if (!got || rd !== 32'h77777777) $display("FAIL wrap_top_kept: got %08h (got=%0b) expected 77777777", rd, got); else pass_count++;
        read_single(32'h40000000, rd, got);
        check_count++;
        if (!got || rd !== 32'h0BADF00D) $display("FAIL wrap_w0_kept: got %08h (got=%0b) expected 0BADF00D", rd, got); else pass_count++;
`else
        write_burst(32'h40001FFC, 4'hF, 8'd1, 2);
        read_single(32'h40000000, rd, got);
        check_count++;
        if (!got || rd !== 32'hCAFE0002) $display("FAIL wrap_w0: got %08h (got=%0b) expected CAFE0002", rd, got); else pass_count++;
        cyc();
        beginTransactionIn = 1'b1; addressDataIn = 32'h40001FFC; readNotWriteIn = 1'b1;
        byteEnablesIn = 4'hF; burstSizeIn = 8'd1;
        cyc();
        beginTransactionIn = 1'b0; addressDataIn = '0;
        for (int k = 0; k < 2; k++) begin
            cyc();
            check_count++;
            if (dataValidOut !== 1'b1 || addressDataOut !== wbuf[k])
                $display("FAIL wrap_rd%0d: got v=%0b d=%08h expected v=1 d=%08h", k, dataValidOut, addressDataOut, wbuf[k]);
            else pass_count++;
        end
        cyc();
        check_count++;
        if (endTransactionOut !== 1'b1) $display("FAIL wrap_rd_end: got %0b expected 1", endTransactionOut); else pass_count++;
        cyc();
`endif
        $display("wrap scenario done");
    endtask

`ifndef BUS_SRAM_OVERRUN_ERROR_EN
    task automatic test_overrun_drop();
        logic [31:0] rd;
        bit          got;
        wbuf[0] = 32'h0;
        write_burst(32'h40000054, 4'hF, 8'd0, 1);
        wbuf[0] = 32'hA1A1A1A1; wbuf[1] = 32'hA2A2A2A2;
        write_burst(32'h40000050, 4'hF, 8'd0, 2);
        read_single(32'h40000050, rd, got);
        check_count++;
        if (!got || rd !== 32'hA1A1A1A1) $display("FAIL drop_w20: got %08h (got=%0b) expected A1A1A1A1", rd, got); else pass_count++;
        read_single(32'h40000054, rd, got);
        check_count++;
        if (!got || rd !== 32'h0) $display("FAIL drop_w21: got %08h (got=%0b) expected 00000000", rd, got); else pass_count++;
    endtask
`endif

    task automatic test_reset_midburst();
        cyc();
        beginTransactionIn = 1'b1; addressDataIn = 32'h40000000; readNotWriteIn = 1'b1;
        byteEnablesIn = 4'hF; burstSizeIn = 8'd7;
        cyc();
        beginTransactionIn = 1'b0; addressDataIn = '0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_count++;
            if ({dataValidOut, endTransactionOut, busErrorOut} !== 3'b0 || addressDataOut !== 32'h0)
                $display("FAIL midreset_c%0d: got v=%0b e=%0b err=%0b d=%08h expected all 0",
                         i, dataValidOut, endTransactionOut, busErrorOut, addressDataOut);
            else pass_count++;
            cyc();
        end
    endtask

    initial begin
        reset = 1'b1; beginTransactionIn = 1'b0; addressDataIn = '0; readNotWriteIn = 1'b0;
        byteEnablesIn = '0; burstSizeIn = '0; dataValidIn = 1'b0; endTransactionIn = 1'b0;
        test_reset();
        test_write_burst();
        test_byte_enables();
        test_miss();
        test_misaligned();
        test_read_abort();
        test_wrap();
`ifndef BUS_SRAM_OVERRUN_ERROR_EN
        test_overrun_drop();
`endif
        test_reset_midburst();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
